linear_regression_training: RTL
===============================

LINEAR_REGRESSION_TRAINING -- requirements
Module: linear_regression_training

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 16, number of (x,y) pairs per training run; legal range 2..256.
REQ-002 SHALL have port i_clock  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  single-cycle request to begin a training run.
REQ-005 SHALL have port i_samples_x_in  input  16  sample x, signed two's complement.
REQ-006 SHALL have port i_samples_y_in  input  16  sample y, signed two's complement.
REQ-007 SHALL have port i_samples_vld  input  1  x/y pair valid this cycle.
REQ-008 SHALL have port o_samples_rdy  output  1  block accepts a pair this cycle.
REQ-009 SHALL have port o_busy  output  1  training run in progress (ACCUM through DIV0).
REQ-010 SHALL have port o_theta0_out  output  32  intercept, signed.
REQ-011 SHALL have port o_theta1_out  output  32  slope, signed.
REQ-012 SHALL have port o_theta1_out_vld  output  1  level: both thetas valid and stable.
REQ-013 SHALL have port o_degenerate  output  1  last run had zero x-variance.

Function
REQ-014 SHALL implement states IDLE, ACCUM, CALC1, DIV1, CALC0, DIV0, DONE.
REQ-015 SHALL leave IDLE or DONE for ACCUM on i_start=1; same edge clears Sx, Sy, Sxx, Sxy, sample count, o_theta1_out_vld, o_degenerate.
REQ-016 SHALL ignore i_start in ACCUM, CALC1, DIV1, CALC0, DIV0.
REQ-017 SHALL drive o_samples_rdy=1 only in ACCUM; pair accepted on edge where o_samples_rdy & i_samples_vld; otherwise ignored, gaps allowed.
REQ-018 SHALL accumulate exactly: Sx (24b), Sy (24b), Sxx (40b), Sxy (40b), all signed, sign-extended, no overflow for legal N.
REQ-019 SHALL move ACCUM->CALC1 on the edge accepting pair N_SAMPLES.
REQ-020 CALC1 (1 cycle) SHALL form 64-bit signed num1 = N*Sxy - Sx*Sy, den1 = N*Sxx - Sx*Sx, then enter DIV1.
REQ-021 DIV1 SHALL run a sequential signed divider, exactly 64 cycles, quotient truncated toward zero, then enter CALC0.
REQ-022 SHALL saturate theta1 to [-2^31, 2^31-1].
REQ-023 If den1=0, SHALL force theta1=0 and set o_degenerate=1, keeping DIV1 duration 64 cycles.
REQ-024 CALC0 (1 cycle) SHALL form num0 = Sy - theta1*Sx (64b signed, saturated theta1), den0 = N_SAMPLES, then enter DIV0.
REQ-025 DIV0 SHALL run 64 cycles, truncate toward zero, saturate theta0 to 32b signed, then enter DONE.
REQ-026 On DIV0->DONE edge, SHALL load o_theta0_out and o_theta1_out together and set o_theta1_out_vld=1.
REQ-027 Latency SHALL be fixed: o_theta1_out_vld rises 130 edges after the edge accepting the last pair.
REQ-028 o_theta0_out, o_theta1_out SHALL change only on the DONE-entry edge; during a new run they retain old values with o_theta1_out_vld=0.
REQ-029 o_theta1_out_vld SHALL stay 1 in DONE until i_start or reset.
REQ-030 o_busy SHALL be 1 in ACCUM, CALC1, DIV1, CALC0, DIV0; 0 in IDLE, DONE.

Reset
REQ-031 On i_reset=0, SHALL immediately enter IDLE and clear all accumulators, divider state, sample count.
REQ-032 Reset values: o_theta0_out=0, o_theta1_out=0, o_theta1_out_vld=0, o_degenerate=0, o_samples_rdy=0, o_busy=0.
REQ-033 Reset asserted mid-run (any state) SHALL abort the run; next i_start after release SHALL run normally.

Verification
REQ-034 N=4, x=0,1,2,3, y=1,3,5,7 -> theta1=2, theta0=1, o_degenerate=0, vld exactly 130 edges after last accept.
REQ-035 N=4, x=0,1,2,3, y=10,7,4,1 -> theta1=-3 (0xFFFFFFFD), theta0=10.
REQ-036 N=4, x=0,1,2,3, y=0,1,1,2 -> theta1=0 (0.6 truncated), theta0=1.
REQ-037 N=4, x=5,5,5,5, y=1,2,3,4 -> theta1=0, theta0=2, o_degenerate=1, same latency.
REQ-038 i_samples_vld gaps plus i_start pulses while busy -> results as REQ-034, run not restarted.
REQ-039 Reset during DIV1 -> all outputs 0 next cycle; new i_start with REQ-035 data -> REQ-035 results.

Source files
------------

// File: rtl/linear_regression_training.sv
// linear_regression_training: least-squares fit of y = theta0 + theta1*x over N_SAMPLES streamed pairs.
// One shared 64-cycle restoring divider computes theta1, then theta0, both truncated toward zero and saturated.
module linear_regression_training #(
    parameter int N_SAMPLES = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic signed [15:0] i_samples_x_in,
    input  logic signed [15:0] i_samples_y_in,
    input  logic               i_samples_vld,
    output logic               o_samples_rdy,
    output logic               o_busy,
    output logic signed [31:0] o_theta0_out,
    output logic signed [31:0] o_theta1_out,
    output logic               o_theta1_out_vld,
    output logic               o_degenerate
);
    localparam logic [2:0] IDLE = 3'd0, ACCUM = 3'd1, CALC1 = 3'd2, DIV1 = 3'd3,
                           CALC0 = 3'd4, DIV0 = 3'd5, DONE = 3'd6;
    localparam logic signed [63:0] NS = 64'(N_SAMPLES);
    localparam logic [8:0] LAST = 9'(N_SAMPLES - 1);

    function automatic logic [63:0] abs64(input logic signed [63:0] v);
        return v[63] ? 64'(-v) : 64'(v);
    endfunction

    function automatic logic signed [31:0] sat32(input logic n, input logic [63:0] m);
        logic signed [63:0] q;
        q = n ? -$signed(m) : $signed(m);
        return q > 64'sd2147483647 ? 32'sh7fffffff : q < -64'sd2147483648 ? 32'sh80000000 : q[31:0];
    endfunction

    logic [2:0] state;
    logic signed [23:0] sx, sy;
    logic signed [39:0] sxx, sxy;
    logic [8:0] cnt;
    logic [63:0] rem, quo, dvs;
    logic neg;
    logic [5:0] dcnt;
    logic signed [31:0] theta1;
    logic signed [63:0] num1, den1, num0;
    logic [64:0] r;
    logic ge;
    logic [63:0] rem_nx, quo_nx;
    logic signed [31:0] q_sat;

    // One restoring-division step: the dividend is shifted out of quo while quotient bits shift in.
    always_comb begin
        num1 = NS * 64'(sxy) - 64'(sx) * 64'(sy);
        den1 = NS * 64'(sxx) - 64'(sx) * 64'(sx);
        num0 = 64'(sy) - 64'(theta1) * 64'(sx);
        r = {rem, quo[63]};
        ge = r >= {1'b0, dvs};
        rem_nx = ge ? 64'(r - {1'b0, dvs}) : r[63:0];
        quo_nx = {quo[62:0], ge};
        q_sat = sat32(neg, quo_nx);
    end

    assign o_samples_rdy = state == ACCUM;
    assign o_busy = state != IDLE && state != DONE;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            sx <= '0;
            sy <= '0;
            sxx <= '0;
            sxy <= '0;
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            neg <= 1'b0;
            dcnt <= '0;
            theta1 <= '0;
            o_theta0_out <= '0;
            o_theta1_out <= '0;
            o_theta1_out_vld <= 1'b0;
            o_degenerate <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (i_start) begin
                    state <= ACCUM;
                    sx <= '0;
                    sy <= '0;
                    sxx <= '0;
                    sxy <= '0;
                    cnt <= '0;
                    o_theta1_out_vld <= 1'b0;
                    o_degenerate <= 1'b0;
                end
                ACCUM: if (i_samples_vld) begin
                    sx <= sx + 24'(i_samples_x_in);
                    sy <= sy + 24'(i_samples_y_in);
                    sxx <= sxx + 40'(i_samples_x_in) * 40'(i_samples_x_in);
                    sxy <= sxy + 40'(i_samples_x_in) * 40'(i_samples_y_in);
                    cnt <= cnt + 9'd1;
                    if (cnt == LAST) state <= CALC1;
                end
                CALC1: begin
                    rem <= '0;
                    quo <= abs64(num1);
                    dvs <= abs64(den1);
                    neg <= num1[63] ^ den1[63];
                    dcnt <= '0;
                    o_degenerate <= den1 == 64'sd0;
                    state <= DIV1;
                end
                DIV1: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    dcnt <= dcnt + 6'd1;
                    if (dcnt == 6'd63) begin
                        theta1 <= o_degenerate ? 32'sd0 : q_sat;
                        state <= CALC0;
                    end
                end
                CALC0: begin
                    rem <= '0;
                    quo <= abs64(num0);
                    dvs <= 64'(N_SAMPLES);
                    neg <= num0[63];
                    dcnt <= '0;
                    state <= DIV0;
                end
                DIV0: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    dcnt <= dcnt + 6'd1;
                    if (dcnt == 6'd63) begin
                        o_theta0_out <= q_sat;
                        o_theta1_out <= theta1;
                        o_theta1_out_vld <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
